// File: rtl/bundler_accum.sv
// Multi-beat majority bundler: accumulates NUM_HVS hypervectors per beat into per-dimension
// counts, PAR_BITS dimensions per cycle, and thresholds on the final beat. Macro: BUNDLER_TIEBREAK_EN.
module bundler_accum #(
    parameter int DIMENSIONS = 10000,
    parameter int NUM_HVS    = 5,
    parameter int PAR_BITS   = 2,
    parameter int MAX_BEATS  = 4
) (
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  en,
    input  logic                                  last,
    input  logic [NUM_HVS-1:0][DIMENSIONS-1:0]    hv_array,
    input  logic [DIMENSIONS-1:0]                 tie_hv,
    output logic                                  busy,
    output logic                                  out,
    output logic [DIMENSIONS-1:0]                 hv_out
);

    localparam int N      = DIMENSIONS / PAR_BITS;
    localparam int CNT_W  = $clog2(NUM_HVS * MAX_BEATS + 1);
    localparam int CMP_W  = CNT_W + 1;
    localparam int CHK_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    localparam logic [CHK_W-1:0]  LAST_CHUNK = CHK_W'(N - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(MAX_BEATS - 1);

    function automatic logic [CNT_W-1:0] lane_pop(
        input logic [NUM_HVS-1:0][DIMENSIONS-1:0] v,
        input int                                 lane
    );
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int h = 0; h < NUM_HVS; h++) begin
            acc = acc + CNT_W'(v[h][lane]);
        end
        return acc;
    endfunction

    logic [0:0]                            state_q, state_d;
    logic [CHK_W-1:0]                      chunk_q, chunk_d;
    logic [BEAT_W-1:0]                     beat_cnt_q, beat_cnt_d;
    logic                                  final_q, final_d;
    logic [NUM_HVS-1:0][DIMENSIONS-1:0]    hv_q, hv_d;
    logic [DIMENSIONS-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIMENSIONS-1:0]                 shadow_q, shadow_d;
    logic [DIMENSIONS-1:0]                 hv_out_q, hv_out_d;
    logic                                  out_q, out_d;

    logic [PAR_BITS-1:0][CNT_W-1:0]        sum_s;
    logic [PAR_BITS-1:0][CMP_W-1:0]        twice_s;
    logic [PAR_BITS-1:0]                   res_s;
    logic [CMP_W-1:0]                      total_s;
    logic [DIMENSIONS-1:0][CNT_W-1:0]      cnt_rot_s;
    logic [DIMENSIONS-1:0]                 shadow_rot_s;

`ifdef BUNDLER_TIEBREAK_EN
    logic [DIMENSIONS-1:0]                 tie_q, tie_d;
`else
    logic                                  unused_tie_s;
    assign unused_tie_s = ^tie_hv;
`endif

    // Current chunk always sits in the low PAR_BITS lanes; registers rotate so dim d returns home after N cycles.
    always_comb begin
        total_s      = CMP_W'(NUM_HVS) * (CMP_W'(beat_cnt_q) + CMP_W'(1'b1));
        sum_s        = '0;
        twice_s      = '0;
        res_s        = '0;
        cnt_rot_s    = '0;
        shadow_rot_s = '0;
        for (int p = 0; p < PAR_BITS; p++) begin
            sum_s[p]   = cnt_q[p] + lane_pop(hv_q, p);
            twice_s[p] = {sum_s[p], 1'b0};
            if (twice_s[p] > total_s) begin
                res_s[p] = 1'b1;
            end else if (twice_s[p] < total_s) begin
                res_s[p] = 1'b0;
            end else begin
`ifdef BUNDLER_TIEBREAK_EN
                res_s[p] = tie_q[p];
`else
                res_s[p] = 1'b0;
`endif
            end
        end
        for (int i = 0; i < DIMENSIONS - PAR_BITS; i++) begin
            cnt_rot_s[i]    = cnt_q[i + PAR_BITS];
            shadow_rot_s[i] = shadow_q[i + PAR_BITS];
        end
        for (int p = 0; p < PAR_BITS; p++) begin
            cnt_rot_s[DIMENSIONS - PAR_BITS + p]    = sum_s[p];
            shadow_rot_s[DIMENSIONS - PAR_BITS + p] = res_s[p];
        end
    end

    // Beat sequencing: capture on en in IDLE, walk chunks in PASS, publish or count the beat at the end.
    always_comb begin
        state_d    = state_q;
        chunk_d    = chunk_q;
        beat_cnt_d = beat_cnt_q;
        final_d    = final_q;
        hv_d       = hv_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        hv_out_d   = hv_out_q;
        out_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    hv_d    = hv_array;
                    final_d = last | (beat_cnt_q == LAST_BEAT);
                    chunk_d = '0;
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                for (int h = 0; h < NUM_HVS; h++) begin
                    hv_d[h] = hv_q[h] >> PAR_BITS;
                end
                cnt_d = cnt_rot_s;
                if (final_q) begin
                    shadow_d = shadow_rot_s;
                end else begin
                    shadow_d = shadow_q;
                end
                if (chunk_q == LAST_CHUNK) begin
                    state_d = ST_IDLE;
                    chunk_d = '0;
                    if (final_q) begin
                        out_d      = 1'b1;
                        hv_out_d   = shadow_rot_s;
                        cnt_d      = '0;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1'b1);
                    end
                end else begin
                    chunk_d = chunk_q + CHK_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial bundle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            chunk_q    <= '0;
            beat_cnt_q <= '0;
            final_q    <= 1'b0;
            hv_q       <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            hv_out_q   <= '0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            chunk_q    <= chunk_d;
            beat_cnt_q <= beat_cnt_d;
            final_q    <= final_d;
            hv_q       <= hv_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            hv_out_q   <= hv_out_d;
            out_q      <= out_d;
        end
    end

`ifdef BUNDLER_TIEBREAK_EN
    // Tie vector rotates with the chunk walk like the hypervectors.
    always_comb begin
        tie_d = tie_q;
        if ((state_q == ST_IDLE) && en) begin
            tie_d = tie_hv;
        end else if (state_q == ST_PASS) begin
            tie_d = tie_q >> PAR_BITS;
        end else begin
            tie_d = tie_q;
        end
    end

    // Tie vector register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tie_q <= '0;
        end else begin
            tie_q <= tie_d;
        end
    end
`endif

    assign busy   = (state_q == ST_PASS);
    assign out    = out_q;
    assign hv_out = hv_out_q;

endmodule

// File: tb/tb_bundler_accum.sv
// Scoreboard bench for bundler_accum: a count-based majority model predicts each bundle,
// a negedge monitor checks every out pulse and that hv_out holds between pulses.
module tb_bundler_accum;
    localparam int D  = 6;
    localparam int H  = 5;
    localparam int P  = 2;
    localparam int MB = 4;
    localparam int N  = D / P;

    logic              clk = 1'b0;
    logic              nrst;
    logic              en;
    logic              last;
    logic [H-1:0][D-1:0] hv_array;
    logic [D-1:0]      tie_hv;
    logic              busy;
    logic              out;
    logic [D-1:0]      hv_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [D-1:0] exp_q[$];
    logic [D-1:0] exp_held = '0;
    int           acc[D];
    int           beats = 0;

    always #5 clk = ~clk;

    bundler_accum #(.DIMENSIONS(D), .NUM_HVS(H), .PAR_BITS(P), .MAX_BEATS(MB)) dut (
        .clk(clk), .nrst(nrst), .en(en), .last(last), .hv_array(hv_array),
        .tie_hv(tie_hv), .busy(busy), .out(out), .hv_out(hv_out)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endfunction

    function automatic logic [H-1:0][D-1:0] mk(input logic [D-1:0] e0, e1, e2, e3, e4);
        logic [H-1:0][D-1:0] v;
        v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3; v[4] = e4;
        return v;
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < D; d++) acc[d] = 0;
        beats = 0;
    endfunction

    // Reference: raw vote totals per dimension, majority over all votes cast so far.
    function automatic bit model_beat(input logic [H-1:0][D-1:0] hv, input logic l, input logic [D-1:0] t);
        bit           fin;
        logic [D-1:0] r;
        int           votes;
        for (int d = 0; d < D; d++)
            for (int h = 0; h < H; h++) acc[d] += int'(hv[h][d]);
        beats++;
        fin = l || (beats == MB);
        if (fin) begin
            votes = H * beats;
            for (int d = 0; d < D; d++) begin
                if (2 * acc[d] > votes) r[d] = 1'b1;
                else if (2 * acc[d] < votes) r[d] = 1'b0;
`ifdef BUNDLER_TIEBREAK_EN
                else r[d] = t[d];
`else
                else r[d] = 1'b0;
`endif
            end
            exp_q.push_back(r);
            model_clear();
        end
        return fin;
    endfunction

    // Monitor: every out pulse must match the next queued bundle; otherwise hv_out must hold.
    always @(negedge clk) begin
        if (nrst) begin
            if (out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out), 32'd0);
                end else begin
                    logic [D-1:0] e;
                    e = exp_q.pop_front();
                    chk("bundle", 32'(hv_out), 32'(e));
                    exp_held = e;
                end
            end else begin
                chk("hv_held", 32'(hv_out), 32'(exp_held));
            end
        end
    end

    task automatic issue(input logic [H-1:0][D-1:0] hv, input logic l, input logic [D-1:0] t, input bit extra);
        bit               fin;
        logic [H*D-1:0]   r;
        @(negedge clk);
        en = 1'b1; last = l; hv_array = hv; tie_hv = t;
        fin = model_beat(hv, l, t);
        @(posedge clk); #1;
        chk("busy_rise", 32'(busy), 32'd1);
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            en = extra && (c <= 2);
            last = 1'b1;
            r = (H*D)'($urandom);
            hv_array = r;
            tie_hv = D'($urandom);
            @(posedge clk); #1;
            if (c < N) begin
                chk("busy_hold", 32'(busy), 32'd1);
                chk("out_early", 32'(out), 32'd0);
            end else begin
                chk("busy_fall", 32'(busy), 32'd0);
                chk("out_pulse", 32'(out), 32'(fin));
            end
        end
        en = 1'b0;
    endtask

    logic [H-1:0][D-1:0] v1, v2, v3;
    logic [H*D-1:0]      rnd;

    initial begin
        v1 = mk(6'b001101, 6'b000111, 6'b001111, 6'b100011, 6'b100011);
        v2 = mk(6'b000010, 6'b010000, 6'b001000, 6'b010100, 6'b000100);
        v3 = mk(6'b111011, 6'b011011, 6'b001111, 6'b010111, 6'b110101);
        model_clear();
        nrst = 1'b0; en = 1'b0; last = 1'b0; hv_array = '0; tie_hv = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_hv", 32'(hv_out), 32'd0);
        nrst = 1'b1;

        issue(v1, 1'b1, 6'b000000, 1'b0);
        @(negedge clk); chk("single_beat", 32'(hv_out), 32'h07);

        issue(v1, 1'b0, 6'b000000, 1'b0);
        chk("beat1_hv_kept", 32'(hv_out), 32'h07);
        issue(v2, 1'b1, 6'b101010, 1'b0);
        @(negedge clk);
`ifdef BUNDLER_TIEBREAK_EN
        chk("tie_two_beats", 32'(hv_out), 32'h02);
`else
        chk("tie_two_beats", 32'(hv_out), 32'h00);
`endif

        issue(v1, 1'b1, 6'b000000, 1'b1);
        @(negedge clk); chk("en_ignored", 32'(hv_out), 32'h07);

        for (int b = 0; b < MB; b++) issue(v3, 1'b0, 6'b000000, 1'b0);
        @(negedge clk); chk("forced_final", 32'(hv_out), 32'h1f);
        issue(v1, 1'b1, 6'b000000, 1'b0);
        @(negedge clk); chk("restart_zero", 32'(hv_out), 32'h07);

        // Reset during chunk 1 of a final beat.
        @(negedge clk);
        en = 1'b1; last = 1'b1; hv_array = v3;
        @(posedge clk); #1; en = 1'b0;
        @(posedge clk);
        @(negedge clk); #2;
        nrst = 1'b0;
        exp_q.delete(); exp_held = '0; model_clear();
        #1;
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hv", 32'(hv_out), 32'd0);
        @(negedge clk); #2; nrst = 1'b1;
        issue(v3, 1'b1, 6'b000000, 1'b0);
        @(negedge clk); chk("after_rst", 32'(hv_out), 32'h1f);

        for (int b = 0; b < 30; b++) begin
            int nb;
            nb = int'($urandom_range(1, MB));
            for (int j = 0; j < nb; j++) begin
                logic l;
                l = (j == nb - 1) && !((nb == MB) && ($urandom_range(0, 1) == 1));
                rnd = (H*D)'($urandom);
                issue(rnd, l, D'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bundler_accum.md
# bundler_accum

Multi-beat majority bundler for the HDC encoder path. It accumulates NUM_HVS hypervectors per beat over one or more beats, keeping a per-dimension saturating count. On the final beat it thresholds the totals into one bundled hypervector. Work is chunked PAR_BITS dimensions per cycle. It sits between the spatial/temporal binders and the associative-memory/classifier stage.

## Interface
- DIMENSIONS, 10000: hypervector width; must be a multiple of PAR_BITS.
- NUM_HVS, 5: hypervectors presented per beat.
- PAR_BITS, 2: dimensions processed per cycle; N = DIMENSIONS/PAR_BITS cycles per pass.
- MAX_BEATS, 4: maximum beats per bundle.
- CNT_W, derived: $clog2(NUM_HVS*MAX_BEATS+1); per-dimension counter width.
- clk  in  1  clock; all state on rising edge.
- nrst  in  1  reset; asynchronous, active-low.
- en  in  1  beat start; sampled only while busy=0.
- last  in  1  sampled with en; marks the beat as final.
- hv_array  in  [NUM_HVS-1:0][DIMENSIONS-1:0]  input hypervectors; sampled with en.
- tie_hv  in  DIMENSIONS  tie-break vector; sampled with en on the final beat.
- busy  out  1  pass in progress.
- out  out  1  one-cycle done pulse; hv_out valid.
- hv_out  out  DIMENSIONS  bundled result; held until the next done.

## Operation
- States: IDLE, PASS.
- IDLE + en: capture hv_array, last, and tie_hv into input registers. Latch final = last OR (beat_cnt == MAX_BEATS-1). Clear chunk index. Go to PASS with busy=1.
- PASS, each cycle, chunk c (dims c*PAR_BITS .. c*PAR_BITS+PAR_BITS-1):
  - sum_d = cnt_d + popcount over NUM_HVS of bit d.
  - Write sum_d back to cnt_d. Saturation is unreachable by construction.
- On a final pass, threshold each sum_d into a shadow result. The total is T = NUM_HVS*(beat_cnt+1).
  - 2*sum_d > T gives 1.
  - 2*sum_d < T gives 0.
  - 2*sum_d == T is a tie; see Configuration.
  - Compare widths are CNT_W+1 bits.
- After chunk N-1:
  - Non-final pass: beat_cnt++, return to IDLE. No out pulse, hv_out unchanged.
  - Final pass: hv_out <= shadow, out=1 for one cycle, all cnt_d and beat_cnt cleared, return to IDLE.
- en while busy=1 is ignored and not queued.
- A beat reaching MAX_BEATS without last is forced final.
- Reset (any time, including mid-pass): busy=0, out=0, hv_out=0, all counters 0, beat_cnt=0, state IDLE. The partial bundle is discarded.

## Timing
- en sampled at edge k; busy high after edge k.
- Chunks 0..N-1 are processed at edges k+1..k+N.
- At edge k+N, busy falls. On a final pass, out rises at the same edge and falls at edge k+N+1.
- The earliest next en is sampled at edge k+N+1, which gives N+1 cycles per beat.
- hv_out changes only at the edge where out rises.

## Configuration
- BUNDLER_TIEBREAK_EN defined: a tie on dimension d takes tie_hv[d], using the value sampled with the final beat's en.
- Undefined: ties resolve to 0. The tie_hv port remains present but is ignored.
- Odd NUM_HVS with a single beat never ties, so behaviour is identical in both builds.

## Test plan
Bench settings: DIMENSIONS=6, NUM_HVS=5, PAR_BITS=2, MAX_BEATS=4, so N=3.
- Single final beat. Stimulus: en=1, last=1, hv_array={001101,000111,001111,100011,100011} (entries 0..4). Required: out pulses after edge k+3, hv_out=000111, busy low from that edge.
- Two beats, tie path.
  - Beat 1: the vectors above with last=0. Required: no out, hv_out unchanged.
  - Beat 2: {000010,010000,001000,010100,000100} with last=1 and tie_hv=101010.
  - Required: hv_out=000000 without the macro, 000010 with BUNDLER_TIEBREAK_EN.
- en pulsed at edges k+1 and k+2 during a pass. Required: ignored; exactly one beat counted and a single out pulse.
- Forced final: four beats of {111011,011011,001111,010111,110101}, all with last=0. Required: out after the fourth pass, hv_out=011111, next bundle starts from zero counts.
- Reset mid-pass: nrst low during chunk 1 of a final beat. Required: immediately out=0, busy=0, hv_out=000000. A following single final beat of {111011,011011,001111,010111,110101} yields hv_out=011111.
